// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper and the game controller.
// Holds the controlSig phase encodings, field widths and FSM states.
package score_keeper_pkg;

    localparam int unsigned SCORE_W     = 7;
    localparam int unsigned PID_W       = 3;
    localparam int unsigned NUM_PLAYERS = 1 << PID_W;
    localparam int unsigned SIG_W       = 3;

    localparam logic [SIG_W-1:0] SIG_INIT     = 3'd0;
    localparam logic [SIG_W-1:0] SIG_SETUP    = 3'd1;
    localparam logic [SIG_W-1:0] SIG_GAME     = 3'd2;
    localparam logic [SIG_W-1:0] SIG_GAMEOVER = 3'd3;
    localparam logic [SIG_W-1:0] SIG_TOP      = 3'd4;
    localparam logic [SIG_W-1:0] SIG_BEST     = 3'd5;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [PID_W-1:0]   pid_t;

    // Finishing result captured from the controller at game-over
    typedef struct packed {
        score_t score;
        pid_t   pid;
    } gameResult_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/score_keeper_if.sv
// Controller-to-score-keeper link plus the display/pulse outputs.
// master = controller/stimulus side, slave = score keeper.
interface score_keeper_if;
    import score_keeper_pkg::*;

    logic [SIG_W-1:0] controlSig;
    score_t           scoreIn;
    pid_t             pIDin;
    logic             isGuestIn;
    pid_t             curPID;
    score_t           dispScore;
    pid_t             dispPID;
    logic             dispValid;
    logic             newTop;
    logic             newBest;

    modport master (
        output controlSig, scoreIn, pIDin, isGuestIn, curPID,
        input  dispScore, dispPID, dispValid, newTop, newBest
    );

    modport slave (
        input  controlSig, scoreIn, pIDin, isGuestIn, curPID,
        output dispScore, dispPID, dispValid, newTop, newBest
    );

endinterface

// File: rtl/score_keeper_best_table.sv
// Per-player personal-best storage: flop array with valid bits,
// one write port and two asynchronous read ports (update and display).
module score_keeper_best_table
    import score_keeper_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   we,
    input  pid_t   wAddr,
    input  score_t wData,
    input  pid_t   updAddr,
    output score_t updScore_c,
    output logic   updValid_c,
    input  pid_t   dispAddr,
    output score_t dispScore_c,
    output logic   dispValid_c
);

    score_t                 best [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] bestValid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                best[i] <= '0;
            end
            bestValid <= '0;
        end else if (we) begin
            best[wAddr]      <= wData;
            bestValid[wAddr] <= 1'b1;
        end
    end

    assign updScore_c  = best[updAddr];
    assign updValid_c  = bestValid[updAddr];
    assign dispScore_c = best[dispAddr];
    assign dispValid_c = bestValid[dispAddr];

endmodule

// File: rtl/score_keeper.sv
// Records finishing scores into personal-best and overall-top storage on
// each non-guest game-over, and drives the top-score display screens.
module score_keeper
    import score_keeper_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    score_keeper_if.slave  bus
);

    state_t           state;
    state_t           stateNext;
    logic [SIG_W-1:0] prevSig;
    gameResult_t      sample;
    score_t           topScore;
    pid_t             topPID;
    logic             topValid;

    logic   gameOverEntry;
    logic   sampleEn;
    logic   bestWe;
    logic   topWe;
    logic   newBestNext;
    logic   newTopNext;
    score_t updScore;
    logic   updValid;
    score_t rdScore;
    logic   rdValid;

    score_keeper_best_table uTable (
        .clk         (clk),
        .rst         (rst),
        .we          (bestWe),
        .wAddr       (sample.pid),
        .wData       (sample.score),
        .updAddr     (sample.pid),
        .updScore_c  (updScore),
        .updValid_c  (updValid),
        .dispAddr    (bus.curPID),
        .dispScore_c (rdScore),
        .dispValid_c (rdValid)
    );

    assign gameOverEntry = (bus.controlSig == SIG_GAMEOVER) && (prevSig != SIG_GAMEOVER);

    // Next-state and update decisions; strictly-greater keeps the holder on ties
    always_comb begin
        stateNext   = state;
        sampleEn    = 1'b0;
        bestWe      = 1'b0;
        topWe       = 1'b0;
        newBestNext = 1'b0;
        newTopNext  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gameOverEntry) stateNext = ST_SETTLE;
            end
            ST_SETTLE: stateNext = ST_SAMPLE;
            ST_SAMPLE: begin
                sampleEn  = 1'b1;
                stateNext = bus.isGuestIn ? ST_HOLD : ST_UPDATE;
            end
            ST_UPDATE: begin
                if (!updValid || (sample.score > updScore)) begin
                    bestWe      = 1'b1;
                    newBestNext = 1'b1;
                end
                if (!topValid || (sample.score > topScore)) begin
                    topWe      = 1'b1;
                    newTopNext = 1'b1;
                end
                stateNext = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.controlSig != SIG_GAMEOVER) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            prevSig       <= '0;
            sample        <= '0;
            topScore      <= '0;
            topPID        <= '0;
            topValid      <= 1'b0;
            bus.newBest   <= 1'b0;
            bus.newTop    <= 1'b0;
            bus.dispScore <= '0;
            bus.dispPID   <= '0;
            bus.dispValid <= 1'b0;
        end else begin
            state       <= stateNext;
            prevSig     <= bus.controlSig;
            bus.newBest <= newBestNext;
            bus.newTop  <= newTopNext;
            if (sampleEn) begin
                sample.score <= bus.scoreIn;
                sample.pid   <= bus.pIDin;
            end
            if (topWe) begin
                topScore <= sample.score;
                topPID   <= sample.pid;
                topValid <= 1'b1;
            end
            // Display fields are zeroed whenever the selected entry is empty
            case (bus.controlSig)
                SIG_TOP: begin
                    bus.dispScore <= topValid ? topScore : '0;
                    bus.dispPID   <= topValid ? topPID : '0;
                    bus.dispValid <= topValid;
                end
                SIG_BEST: begin
                    bus.dispScore <= rdValid ? rdScore : '0;
                    bus.dispPID   <= rdValid ? bus.curPID : '0;
                    bus.dispValid <= rdValid;
                end
                default: begin
                    bus.dispScore <= '0;
                    bus.dispPID   <= '0;
                    bus.dispValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: game-over recording, ties, guests,
// held game-over, and reset abort, checked with immediate assertions.
module tb_score_keeper;
    import score_keeper_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   nBest;
    int   nTop;
    int   nBoth;

    score_keeper_if bus ();

    score_keeper dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one game-over from fromSig, hold GAMEOVER for holdCycles and count pulses
    task automatic runGame(input logic [SIG_W-1:0] fromSig, input pid_t pid, input score_t score,
                           input logic guest, input int holdCycles,
                           output int cBest, output int cTop, output int cBoth);
        bus.controlSig = fromSig;
        tick();
        bus.controlSig = SIG_GAMEOVER;
        bus.scoreIn    = score;
        bus.pIDin      = pid;
        bus.isGuestIn  = guest;
        cBest = 0;
        cTop  = 0;
        cBoth = 0;
        repeat (holdCycles) begin
            tick();
            if (bus.newBest === 1'b1) cBest++;
            if (bus.newTop === 1'b1) cTop++;
            if (bus.newBest === 1'b1 && bus.newTop === 1'b1) cBoth++;
        end
        bus.controlSig = SIG_INIT;
        tick();
        if (bus.newBest === 1'b1) cBest++;
        if (bus.newTop === 1'b1) cTop++;
    endtask

    task automatic show(input logic [SIG_W-1:0] sig, input pid_t cur);
        bus.controlSig = sig;
        bus.curPID     = cur;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.controlSig = SIG_INIT;
        bus.scoreIn    = '0;
        bus.pIDin      = '0;
        bus.isGuestIn  = 1'b0;
        bus.curPID     = '0;
        tick();
        tick();
        check("rst_newBest", 32'(bus.newBest), 0);
        check("rst_newTop", 32'(bus.newTop), 0);
        check("rst_dispValid", 32'(bus.dispValid), 0);
        rst = 1'b1;
        tick();

        show(SIG_TOP, 3'd0);
        check("empty_top_valid", 32'(bus.dispValid), 0);
        check("empty_top_score", 32'(bus.dispScore), 0);
        check("empty_top_pid", 32'(bus.dispPID), 0);
        show(SIG_BEST, 3'd2);
        check("empty_best2_valid", 32'(bus.dispValid), 0);

        runGame(SIG_GAME, 3'd3, 7'd12, 1'b0, 8, nBest, nTop, nBoth);
        check("g1_newBest", 32'(nBest), 1);
        check("g1_newTop", 32'(nTop), 1);
        check("g1_same_cycle", 32'(nBoth), 1);
        show(SIG_TOP, 3'd0);
        check("g1_top_score", 32'(bus.dispScore), 12);
        check("g1_top_pid", 32'(bus.dispPID), 3);
        check("g1_top_valid", 32'(bus.dispValid), 1);
        show(SIG_BEST, 3'd3);
        check("g1_best3_score", 32'(bus.dispScore), 12);
        check("g1_best3_pid", 32'(bus.dispPID), 3);
        show(SIG_INIT, 3'd0);
        check("idle_disp_valid", 32'(bus.dispValid), 0);

        runGame(SIG_GAME, 3'd5, 7'd12, 1'b0, 8, nBest, nTop, nBoth);
        check("tie_newBest", 32'(nBest), 1);
        check("tie_newTop", 32'(nTop), 0);
        show(SIG_TOP, 3'd0);
        check("tie_top_score", 32'(bus.dispScore), 12);
        check("tie_top_pid", 32'(bus.dispPID), 3);
        show(SIG_BEST, 3'd5);
        check("tie_best5_score", 32'(bus.dispScore), 12);

        runGame(SIG_GAME, 3'd5, 7'd20, 1'b0, 8, nBest, nTop, nBoth);
        check("g3_newBest", 32'(nBest), 1);
        check("g3_newTop", 32'(nTop), 1);
        show(SIG_TOP, 3'd0);
        check("g3_top_score", 32'(bus.dispScore), 20);
        check("g3_top_pid", 32'(bus.dispPID), 5);
        show(SIG_BEST, 3'd5);
        check("g3_best5_score", 32'(bus.dispScore), 20);

        runGame(SIG_GAME, 3'd1, 7'd99, 1'b1, 8, nBest, nTop, nBoth);
        check("guest_newBest", 32'(nBest), 0);
        check("guest_newTop", 32'(nTop), 0);
        show(SIG_TOP, 3'd0);
        check("guest_top_score", 32'(bus.dispScore), 20);
        show(SIG_BEST, 3'd1);
        check("guest_best1_valid", 32'(bus.dispValid), 0);
        check("guest_best1_score", 32'(bus.dispScore), 0);

        runGame(SIG_GAME, 3'd6, 7'd7, 1'b0, 50, nBest, nTop, nBoth);
        check("held_newBest", 32'(nBest), 1);
        check("held_newTop", 32'(nTop), 0);
        show(SIG_BEST, 3'd6);
        check("held_best6_score", 32'(bus.dispScore), 7);

        runGame(SIG_INIT, 3'd3, 7'd10, 1'b0, 8, nBest, nTop, nBoth);
        check("lower_newBest", 32'(nBest), 0);
        check("lower_newTop", 32'(nTop), 0);
        show(SIG_BEST, 3'd3);
        check("lower_best3_score", 32'(bus.dispScore), 12);

        // Game-over with score 30, then reset while in SETTLE
        bus.controlSig = SIG_INIT;
        tick();
        bus.controlSig = SIG_GAMEOVER;
        bus.scoreIn    = 7'd30;
        bus.pIDin      = 3'd2;
        bus.isGuestIn  = 1'b0;
        tick();
        rst = 1'b0;
        bus.controlSig = SIG_INIT;
        nBest = 0;
        nTop  = 0;
        tick();
        rst = 1'b1;
        repeat (6) begin
            tick();
            if (bus.newBest === 1'b1) nBest++;
            if (bus.newTop === 1'b1) nTop++;
        end
        check("abort_newBest", 32'(nBest), 0);
        check("abort_newTop", 32'(nTop), 0);
        show(SIG_TOP, 3'd0);
        check("abort_top_valid", 32'(bus.dispValid), 0);
        show(SIG_BEST, 3'd2);
        check("abort_best2_valid", 32'(bus.dispValid), 0);
        show(SIG_BEST, 3'd3);
        check("abort_best3_valid", 32'(bus.dispValid), 0);
        check("abort_best3_score", 32'(bus.dispScore), 0);
        show(SIG_BEST, 3'd5);
        check("abort_best5_valid", 32'(bus.dispValid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
